// File: rtl/rip_pkg.sv
// rip_pkg: shared opcodes, funct7 constants, decoded-instruction flags and decode packet
package rip_pkg;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam logic [31:0] ECALL_CODE  = 32'h0000_0073;
   localparam logic [31:0] EBREAK_CODE = 32'h0010_0073;
   localparam logic [31:0] MRET_CODE   = 32'h3020_0073;
   localparam int PKT_PC_W = 64;
   typedef struct packed {
      logic LUI, AUIPC, JAL, JALR;
      logic BEQ, BNE, BLT, BGE, BLTU, BGEU;
      logic LB, LH, LW, LBU, LHU, SB, SH, SW;
      logic ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
      logic ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
      logic FENCE, ECALL, EBREAK, MRET;
      logic CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI;
      logic MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU;
      logic ILLEGAL, UPDATE_REG, UPDATE_PC;
   } inst_t;
   typedef struct packed {
      logic [4:0]          rs1_num;
      logic [4:0]          rs2_num;
      logic [4:0]          rd_num;
      logic [11:0]         csr_num;
      logic [4:0]          csr_zimm;
      logic [31:0]         imm;
      inst_t               inst;
      logic [PKT_PC_W-1:0] pc;
      logic                illegal;
   } de_pkt_t;
endpackage

// File: rtl/rip_decode_comb.sv
// rip_decode_comb: combinational RV32I+Zicsr(+M) decoder, inst_code -> de_pkt_t with pc left zero
//   inst_code : raw 32-bit instruction
//   dec       : decoded packet; illegal encodings yield a trap packet with registers zeroed
module rip_decode_comb
   import rip_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0] inst_code,
   output de_pkt_t     dec
);
   logic [6:0] opc, f7;
   logic [2:0] f3;
   logic [4:0] rd, rs1, rs2;
   logic is_op, is_opi, is_load, is_store, is_br, is_jal, is_jalr, is_lui, is_auipc, is_sys, is_misc;
   logic is_md, is_alu, is_csr, is_shi, op_ok, opi_ok, sys_ok, illegal;
   logic uses_rd, uses_rs1, uses_rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   inst_t raw, trap;
   assign opc = inst_code[6:0];
   assign rd  = inst_code[11:7];
   assign f3  = inst_code[14:12];
   assign rs1 = inst_code[19:15];
   assign rs2 = inst_code[24:20];
   assign f7  = inst_code[31:25];
   assign is_op    = opc == OP;
   assign is_opi   = opc == OP_IMM;
   assign is_load  = opc == LOAD;
   assign is_store = opc == STORE;
   assign is_br    = opc == BRANCH;
   assign is_jal   = opc == JAL;
   assign is_jalr  = opc == JALR;
   assign is_lui   = opc == LUI;
   assign is_auipc = opc == AUIPC;
   assign is_sys   = opc == SYSTEM;
   assign is_misc  = opc == MISC_MEM;
   assign is_md  = is_op & f7 == F7_MULDIV;
   assign is_alu = is_op & !is_md;
   assign is_csr = is_sys & f3[1:0] != 2'd0;
   assign is_shi = is_opi & f3[1:0] == 2'b01;
   // ALT funct7 is only defined for SUB and SRA
   assign op_ok  = f7 == F7_BASE | (f7 == F7_ALT & (f3 == 3'b000 | f3 == 3'b101)) | (f7 == F7_MULDIV & ENABLE_M);
   assign opi_ok = f3 == 3'b001 ? f7 == F7_BASE : f3 == 3'b101 ? (f7 == F7_BASE | f7 == F7_ALT) : 1'b1;
   assign sys_ok = f3 != 3'b000 | inst_code == ECALL_CODE | inst_code == EBREAK_CODE | inst_code == MRET_CODE;
   assign illegal = !(is_op | is_opi | is_load | is_store | is_br | is_jal | is_jalr | is_lui | is_auipc | is_sys | is_misc)
                    | (is_op & !op_ok) | (is_opi & !opi_ok) | (is_sys & !sys_ok);
   assign uses_rd  = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opi | is_op | is_csr;
   assign uses_rs1 = is_jalr | is_br | is_load | is_store | is_opi | is_op | (is_csr & !f3[2]);
   assign uses_rs2 = is_br | is_store | is_op;
   assign imm_i = {{20{inst_code[31]}}, inst_code[31:20]};
   assign imm_s = {{20{inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
   assign imm_b = {{19{inst_code[31]}}, inst_code[31], inst_code[7], inst_code[30:25], inst_code[11:8], 1'b0};
   assign imm_u = {inst_code[31:12], 12'd0};
   assign imm_j = {{11{inst_code[31]}}, inst_code[31], inst_code[19:12], inst_code[20], inst_code[30:21], 1'b0};
   always_comb begin
      raw = '0;
      raw.LUI    = is_lui;
      raw.AUIPC  = is_auipc;
      raw.JAL    = is_jal;
      raw.JALR   = is_jalr;
      raw.BEQ    = is_br & f3 == 3'd0;
      raw.BNE    = is_br & f3 == 3'd1;
      raw.BLT    = is_br & f3 == 3'd4;
      raw.BGE    = is_br & f3 == 3'd5;
      raw.BLTU   = is_br & f3 == 3'd6;
      raw.BGEU   = is_br & f3 == 3'd7;
      raw.LB     = is_load & f3 == 3'd0;
      raw.LH     = is_load & f3 == 3'd1;
      raw.LW     = is_load & f3 == 3'd2;
      raw.LBU    = is_load & f3 == 3'd4;
      raw.LHU    = is_load & f3 == 3'd5;
      raw.SB     = is_store & f3 == 3'd0;
      raw.SH     = is_store & f3 == 3'd1;
      raw.SW     = is_store & f3 == 3'd2;
      raw.ADDI   = is_opi & f3 == 3'd0;
      raw.SLLI   = is_opi & f3 == 3'd1;
      raw.SLTI   = is_opi & f3 == 3'd2;
      raw.SLTIU  = is_opi & f3 == 3'd3;
      raw.XORI   = is_opi & f3 == 3'd4;
      raw.SRLI   = is_opi & f3 == 3'd5 & !f7[5];
      raw.SRAI   = is_opi & f3 == 3'd5 & f7[5];
      raw.ORI    = is_opi & f3 == 3'd6;
      raw.ANDI   = is_opi & f3 == 3'd7;
      raw.ADD    = is_alu & f3 == 3'd0 & !f7[5];
      raw.SUB    = is_alu & f3 == 3'd0 & f7[5];
      raw.SLL    = is_alu & f3 == 3'd1;
      raw.SLT    = is_alu & f3 == 3'd2;
      raw.SLTU   = is_alu & f3 == 3'd3;
      raw.XOR    = is_alu & f3 == 3'd4;
      raw.SRL    = is_alu & f3 == 3'd5 & !f7[5];
      raw.SRA    = is_alu & f3 == 3'd5 & f7[5];
      raw.OR     = is_alu & f3 == 3'd6;
      raw.AND    = is_alu & f3 == 3'd7;
      raw.MUL    = is_md & f3 == 3'd0;
      raw.MULH   = is_md & f3 == 3'd1;
      raw.MULHSU = is_md & f3 == 3'd2;
      raw.MULHU  = is_md & f3 == 3'd3;
      raw.DIV    = is_md & f3 == 3'd4;
      raw.DIVU   = is_md & f3 == 3'd5;
      raw.REM    = is_md & f3 == 3'd6;
      raw.REMU   = is_md & f3 == 3'd7;
      raw.FENCE  = is_misc;
      raw.ECALL  = inst_code == ECALL_CODE;
      raw.EBREAK = inst_code == EBREAK_CODE;
      raw.MRET   = inst_code == MRET_CODE;
      raw.CSRRW  = is_sys & f3 == 3'd1;
      raw.CSRRS  = is_sys & f3 == 3'd2;
      raw.CSRRC  = is_sys & f3 == 3'd3;
      raw.CSRRWI = is_sys & f3 == 3'd5;
      raw.CSRRSI = is_sys & f3 == 3'd6;
      raw.CSRRCI = is_sys & f3 == 3'd7;
      raw.UPDATE_PC = is_jal | is_jalr | is_br | raw.ECALL | raw.EBREAK | raw.MRET;
      trap = '0;
      trap.UPDATE_PC = 1'b1;
      dec = '0;
      dec.illegal  = illegal;
      dec.inst     = illegal ? trap : raw;
      dec.rd_num   = uses_rd & !illegal ? rd : 5'd0;
      dec.rs1_num  = uses_rs1 & !illegal ? rs1 : 5'd0;
      dec.rs2_num  = uses_rs2 & !illegal ? rs2 : 5'd0;
      dec.csr_num  = is_csr & !illegal ? inst_code[31:20] : 12'd0;
      dec.csr_zimm = is_csr & f3[2] & !illegal ? rs1 : 5'd0;
      dec.imm      = illegal ? 32'd0 : is_shi ? {27'd0, inst_code[24:20]} :
                     (is_jalr | is_load | is_opi) ? imm_i : is_store ? imm_s : is_br ? imm_b :
                     (is_lui | is_auipc) ? imm_u : is_jal ? imm_j : 32'd0;
      dec.inst.UPDATE_REG = dec.rd_num != 5'd0 & !illegal;
   end
endmodule

// File: rtl/rip_decode_stage.sv
// rip_decode_stage: registered decode stage with valid/ready handshakes, 2-entry skid, flush and consume counter
//   clk, rst_n            : clock, synchronous active-low reset
//   flush                 : drop main, skid and any packet accepted this cycle
//   in_valid/in_ready     : fetch handshake carrying inst_code and in_pc
//   if_*_num              : early register/CSR numbers, nonzero only on accept
//   out_valid/out_ready   : execute handshake carrying out_pkt (zero when invalid)
//   decode_count          : packets consumed by execute, wrapping
module rip_decode_stage
   import rip_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1,
   parameter int CNT_W    = 32,
   parameter int PC_W     = 32
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [31:0]                  inst_code,
   input  logic [PC_W-1:0]              in_pc,
   output logic [4:0]                   if_rs1_num,
   output logic [4:0]                   if_rs2_num,
   output logic [4:0]                   if_rd_num,
   output logic [11:0]                  if_csr_num,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$bits(de_pkt_t)-1:0]   out_pkt,
   output logic [CNT_W-1:0]             decode_count
);
   de_pkt_t dec, new_pkt, main_pkt, skid_pkt;
   logic main_v, skid_v, acc, con;
   rip_decode_comb #(.ENABLE_M(ENABLE_M)) u_dec (.inst_code(inst_code), .dec(dec));
   always_comb begin
      new_pkt = dec;
      new_pkt.pc = PKT_PC_W'(in_pc);
   end
   // in_ready depends only on the skid register, so out_ready never reaches fetch combinationally
   assign in_ready  = !skid_v;
   assign out_valid = main_v;
   assign acc = in_valid & in_ready;
   assign con = main_v & out_ready;
   assign out_pkt = main_v ? main_pkt : '0;
   assign if_rs1_num = acc ? dec.rs1_num : 5'd0;
   assign if_rs2_num = acc ? dec.rs2_num : 5'd0;
   assign if_rd_num  = acc ? dec.rd_num : 5'd0;
   assign if_csr_num = acc ? dec.csr_num : 12'd0;
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         main_v   <= 1'b0;
         skid_v   <= 1'b0;
         main_pkt <= '0;
         skid_pkt <= '0;
      end else begin
         if (acc && (!main_v || con)) begin
            main_pkt <= new_pkt;
            main_v   <= 1'b1;
         end else if (con) begin
            main_pkt <= skid_pkt;
            main_v   <= skid_v;
         end
         if (acc && main_v && !con) begin
            skid_pkt <= new_pkt;
            skid_v   <= 1'b1;
         end else if (con) begin
            skid_v <= 1'b0;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) decode_count <= '0;
      else if (con && !flush) decode_count <= decode_count + 1'b1;
   end
endmodule

// File: doc/rip_decode_stage.md
Name: rip_decode_stage

Overview:
Parametrised successor to the current decode stage. It decodes RV32I + Zicsr, with optional M-extension and illegal-instruction detection, into one registered decode packet. Input and output use valid/ready handshakes, with a 2-entry skid buffer so backpressure does not combinationally reach fetch. It sits between fetch and execute, and adds pipeline flush and a decoded-instruction counter.

Parameters:
ENABLE_M, 1, when 1 decode MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU; when 0 those encodings are illegal
CNT_W, 32, width of the retired-decode counter
PC_W, 32, width of the PC carried alongside the instruction

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  discard all buffered and in-flight decode state
in_valid  in  1  fetch presents inst_code/in_pc
in_ready  out  1  stage can accept this cycle
inst_code  in  32  raw instruction
in_pc  in  PC_W  instruction PC
if_rs1_num  out  5  early rs1 for regfile read, 0 unless accepted and rs1-using
if_rs2_num  out  5  early rs2, same qualification
if_rd_num  out  5  early rd, same qualification
if_csr_num  out  12  early CSR number, same qualification
out_valid  out  1  out_pkt is valid
out_ready  in  1  execute consumes out_pkt
out_pkt  out  $bits(de_pkt_t)  decoded packet: rs1/rs2/rd, csr_num, csr_zimm, imm, inst (inst_t), pc, illegal
decode_count  out  CNT_W  number of packets handed to execute

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk. Reset drives out_valid=0, out_pkt=0, skid empty, in_ready=1, decode_count=0.
- Decode is combinational on inst_code and is registered on accept (in_valid & in_ready). Latency is 1 cycle from accept to out_valid.
- Immediate and type classification are unchanged from the current stage: I/S/B/U/J sign-extension. Shift-immediate imm = {27'b0, shamt}. csr_zimm is nonzero only for CSR*I forms.
- Register numbers are zeroed when the format does not use them. UPDATE_REG = (rd != 0) & !illegal.
- Illegal when any of the following holds:
  - unknown opcode;
  - unlisted funct3/funct7 for OP/OP-IMM;
  - SLLI/SRLI/SRAI with inst_code[25]=1;
  - M encoding with ENABLE_M=0;
  - SYSTEM funct3=000 other than ECALL, EBREAK or MRET.
- Illegal packet content: illegal=1, inst all zero except UPDATE_PC=1 (trap), rd/rs1/rs2/csr=0.
- Skid buffer:
  - main register drives out_pkt; skid holds one extra packet.
  - in_ready = !skid_valid, registered with no combinational path from out_ready.
  - Accept while main is valid and not consumed: the packet goes to skid.
  - Consume (out_valid & out_ready) with skid valid: skid moves to main and skid empties.
  - Simultaneous accept and consume with skid empty: the new packet overwrites main.
- Bubble: when out_valid=0, out_pkt is all zero, so downstream hazard compares see x0.
- flush has priority over accept and consume in the same cycle. The next cycle has out_valid=0, skid empty, out_pkt=0 and in_ready=1. A packet accepted in the flush cycle is dropped. decode_count does not count a consume in the flush cycle.
- decode_count increments by 1 per consume, wraps at 2^CNT_W, and is not cleared by flush.
- Reset mid-operation behaves identically to power-on reset; buffered packets are lost.

Decomposition:
- rip_pkg: the inst_t extension with MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU and ILLEGAL fields; the de_pkt_t struct; opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM); funct7 constants.
- Sub-module rip_decode_comb: purely combinational inst_code -> de_pkt_t (without pc). rip_decode_stage instantiates it and owns the skid buffer, flush and counter.

Test Plan:
- Single ADDI: 0x00500093 at pc=0x100, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, inst.ADDI=1, UPDATE_REG=1, pc=0x100, decode_count=1.
- MUL with ENABLE_M=1: 0x022081B3 -> inst.MUL=1, rd=3, rs1=1, rs2=2. Same encoding with ENABLE_M=0 -> illegal=1, UPDATE_PC=1, rd=0, UPDATE_REG=0.
- Backpressure: hold out_ready=0 and stream 3 ADDIs back-to-back -> 2 accepted, in_ready=0 on the third. Release out_ready -> packets emerge in order with no loss or duplicate, decode_count=3.
- Flush: while main and skid are full, assert flush with in_valid=1 -> next cycle out_valid=0, out_pkt=0, in_ready=1, decode_count unchanged.
- CSR/shift: 0x3003D2F3 -> CSRRWI, csr_num=0x300, csr_zimm=7, rd=5, rs1_num=0. 0x4030D093 -> SRAI, imm=3. 0x0000_0000 -> illegal=1.
